// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    TRAP      = 3'd6
  } state_t;

  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam int         CNT_W   = 16;

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter: synchronous clear, increment, and end-of-memory detect.
module mips_pc_reg #(
  parameter int PCsize = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [PCsize-1:0] pc,
  output logic              last_addr
);

  localparam logic [PCsize-1:0] PC_ONE = PCsize'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

  // The caller stops incrementing here, so the PC never wraps.
  assign last_addr = &pc;

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning pc and ir.
// Define MIPS_SEQ_OVERFLOW_TRAP_EN to send ALU overflow to the TRAP state.
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int DataSize = 32,
  parameter int PCsize   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DataSize-1:0] instr_in,
  input  logic                ctl_regwrite,
  input  logic [DataSize-1:0] alu_result,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  output logic [PCsize-1:0]   pc,
  output logic [DataSize-1:0] ir,
  output logic                reg_write,
  output logic [DataSize-1:0] wd,
  output logic                zero_q,
  output logic [2:0]          state,
  output logic                busy,
  output logic                halted,
  output logic                trap,
  output logic [PCsize-1:0]   epc,
  output logic [CNT_W-1:0]    instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t st;
  logic   pc_clr;
  logic   pc_inc;
  logic   last_addr;

  assign pc_inc = (st == WRITEBACK) && !last_addr;
  assign pc_clr = ((st == HALT) || (st == TRAP)) && start;

  mips_pc_reg #(
    .PCsize (PCsize)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .clr       (pc_clr),
    .inc       (pc_inc),
    .pc        (pc),
    .last_addr (last_addr)
  );

`ifdef MIPS_SEQ_OVERFLOW_TRAP_EN
  logic [PCsize-1:0] epc_q;
  assign epc  = epc_q;
  assign trap = (st == TRAP);
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
  assign epc        = '0;
  assign trap       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      ir          <= '0;
      wd          <= '0;
      zero_q      <= 1'b0;
      instr_count <= '0;
`ifdef MIPS_SEQ_OVERFLOW_TRAP_EN
      epc_q       <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (start) st <= FETCH;
        end
        FETCH: begin
          ir <= instr_in;
          st <= DECODE;
        end
        DECODE: begin
          st <= (ir[31:26] == OP_HALT) ? HALT : EXECUTE;
        end
        EXECUTE: begin
          wd     <= alu_result;
          zero_q <= alu_zero;
`ifdef MIPS_SEQ_OVERFLOW_TRAP_EN
          if (alu_overflow) begin
            epc_q <= pc;
            st    <= TRAP;
          end else begin
            st    <= WRITEBACK;
          end
`else
          st <= WRITEBACK;
`endif
        end
        WRITEBACK: begin
          if (instr_count != CNT_MAX) instr_count <= instr_count + CNT_ONE;
          st <= last_addr ? HALT : FETCH;
        end
        HALT, TRAP: begin
          // Restart from address 0 with a fresh retire count; pc is cleared in u_pc.
          if (start) begin
            instr_count <= '0;
`ifdef MIPS_SEQ_OVERFLOW_TRAP_EN
            epc_q       <= '0;
`endif
            st          <= FETCH;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Write enable is combinational so a reset in WRITEBACK suppresses the write.
  assign reg_write = (st == WRITEBACK) && ctl_regwrite && !rst;
  assign state     = st;
  assign busy      = (st == FETCH) || (st == DECODE) || (st == EXECUTE) || (st == WRITEBACK);
  assign halted    = (st == HALT);

endmodule

// File: tb/tb_mips_sequencer.sv
// Self-checking bench for mips_sequencer with an instruction-level reference model.
module tb_mips_sequencer;

`ifdef MIPS_SEQ_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, ctl_regwrite, alu_overflow, alu_zero;
  logic [31:0] instr_in, alu_result;
  logic [5:0]  pc, epc;
  logic [31:0] ir, wd;
  logic        reg_write, zero_q, busy, halted, trap;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;
  assign instr_in = mem[pc];

  mips_sequencer #(.DataSize(32), .PCsize(6)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_in(instr_in),
    .ctl_regwrite(ctl_regwrite), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .pc(pc), .ir(ir), .reg_write(reg_write), .wd(wd), .zero_q(zero_q),
    .state(state), .busy(busy), .halted(halted), .trap(trap), .epc(epc),
    .instr_count(instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] non_halt_word();
    logic [31:0] w;
    w = $urandom;
    w[31] = 1'b0;
    return w;
  endfunction

  // Walks the program one instruction at a time from a FETCH cycle.
  // outcome: 0 halted, 1 trapped, 2 reset during writeback of rst_pc.
  task automatic run_prog(input int ovf_pc, input int rst_pc, output int outcome);
    logic [31:0] res;
    logic        z, ovf, wr;
    outcome = -1;
    for (int n = 0; n < 70; n++) begin
      chk("fetch_state", state, 1);
      chk("fetch_pc", pc, exp_pc);
      chk("fetch_busy", busy, 1);
      chk("fetch_rw", reg_write, 0);
      start = 1'($urandom_range(0, 1));
      ctl_regwrite = 1'($urandom_range(0, 1));
      tick;
      chk("dec_state", state, 2);
      chk("dec_ir", ir, mem[exp_pc]);
      chk("dec_rw", reg_write, 0);
      start = 1'($urandom_range(0, 1));
      if (mem[exp_pc][31:26] == 6'h3F) begin
        tick;
        start = 1'b0;
        chk("halt_state", state, 5);
        chk("halt_flag", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc", pc, exp_pc);
        chk("halt_cnt", instr_count, exp_cnt);
        outcome = 0;
        return;
      end
      tick;
      chk("exe_state", state, 3);
      chk("exe_rw", reg_write, 0);
      res = (exp_pc == 1) ? 32'h0000_0005 : $urandom;
      z = 1'($urandom_range(0, 1));
      ovf = (exp_pc == ovf_pc);
      alu_result = res;
      alu_zero = z;
      alu_overflow = ovf;
      start = 1'($urandom_range(0, 1));
      tick;
      alu_overflow = 1'b0;
      alu_result = $urandom;
      alu_zero = ~z;
      if (ovf && TRAP_EN) begin
        start = 1'b0;
        chk("trap_state", state, 6);
        chk("trap_flag", trap, 1);
        chk("trap_epc", epc, exp_pc);
        chk("trap_pc", pc, exp_pc);
        chk("trap_cnt", instr_count, exp_cnt);
        chk("trap_rw", reg_write, 0);
        outcome = 1;
        return;
      end
      chk("wb_state", state, 4);
      chk("wb_wd", wd, res);
      chk("wb_zero", zero_q, z);
      if (exp_pc == rst_pc) begin
        ctl_regwrite = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_wb_rw", reg_write, 0);
        tick;
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_busy", busy, 0);
        exp_pc = 0;
        exp_cnt = 0;
        outcome = 2;
        return;
      end
      wr = 1'($urandom_range(0, 1));
      ctl_regwrite = wr;
      #1;
      chk("wb_rw", reg_write, wr);
      start = 1'($urandom_range(0, 1));
      tick;
      if (exp_cnt < 65535) exp_cnt++;
      chk("retire_cnt", instr_count, exp_cnt);
      if (exp_pc == 63) begin
        start = 1'b0;
        chk("end_state", state, 5);
        chk("end_pc", pc, 63);
        outcome = 0;
        return;
      end
      exp_pc++;
    end
    chk("prog_timeout", 1, 0);
  endtask

  initial begin
    int out;
    rst = 1'b1; start = 1'b0; ctl_regwrite = 1'b0;
    alu_result = '0; alu_overflow = 1'b0; alu_zero = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = non_halt_word();
    tick; tick;
    rst = 1'b0;
    chk("r_state", state, 0); chk("r_pc", pc, 0); chk("r_ir", ir, 0);
    chk("r_wd", wd, 0); chk("r_zero", zero_q, 0); chk("r_cnt", instr_count, 0);
    chk("r_busy", busy, 0); chk("r_halt", halted, 0); chk("r_trap", trap, 0);
    chk("r_epc", epc, 0); chk("r_rw", reg_write, 0);
    tick;
    chk("idle_hold", state, 0);

    // Three adds then HALT.
    mem[0] = 32'h0043_0820; mem[1] = 32'h0085_1020; mem[2] = 32'h00C7_1820;
    mem[3] = 32'hFC00_0000;
    start = 1'b1; tick; exp_pc = 0; exp_cnt = 0;
    run_prog(-1, -1, out);
    chk("t1_outcome", out, 0);
    chk("t1_cnt", instr_count, 3); chk("t1_pc", pc, 3); chk("t1_halted", halted, 1);

    // Start held in HALT restarts at once; then reset during a writeback.
    start = 1'b1; tick; exp_pc = 0; exp_cnt = 0;
    run_prog(-1, 1, out);
    chk("t2_outcome", out, 2);

    // rst beats start in the same cycle.
    rst = 1'b1; start = 1'b1; tick;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_state", state, 0);
    tick;
    chk("rst_start_hold", state, 0);

    // Whole memory without a HALT: stops at the last address.
    for (int i = 0; i < 64; i++) mem[i] = non_halt_word();
    start = 1'b1; tick; exp_pc = 0; exp_cnt = 0;
    run_prog(-1, -1, out);
    chk("full_outcome", out, 0);
    chk("full_pc", pc, 63); chk("full_cnt", instr_count, 64); chk("full_halted", halted, 1);

    // Overflow at pc=2: traps when enabled, otherwise ignored.
    for (int i = 0; i < 64; i++) mem[i] = non_halt_word();
    mem[5] = 32'hFC00_0000;
    start = 1'b1; tick; exp_pc = 0; exp_cnt = 0;
    run_prog(2, -1, out);
    chk("ovf_outcome", out, TRAP_EN ? 1 : 0);
    if (out == 1) begin
      chk("ovf_trap_cnt", instr_count, 2);
      start = 1'b1; tick;
      chk("trap_exit_state", state, 1); chk("trap_exit_pc", pc, 0);
      chk("trap_exit_trap", trap, 0); chk("trap_exit_epc", epc, 0);
      exp_pc = 0; exp_cnt = 0;
      run_prog(-1, -1, out);
    end
    chk("ovf_final_pc", pc, 5);
    chk("ovf_final_cnt", instr_count, 5);
    chk("ovf_final_halted", halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Multi-cycle control sequencer for the single-issue MIPS datapath. It owns the program counter and the instruction register, and steps each instruction through fetch, decode, execute and writeback. It sits between instruction memory, the Control decoder, RegisterFile and ALU, and replaces the free-running, unclocked PC. Register writes are gated so that RegisterFile is written exactly once per instruction, in WRITEBACK only.

## Interface
Parameters:
- DataSize, 32, datapath/instruction width
- PCsize, 6, program counter width (word address into InstructionMemory)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request; sampled in IDLE, HALT, TRAP only
- instr_in  in  DataSize  InstructionMemory read data for address pc
- ctl_regwrite  in  1  RegWrite from Control, decoded from ir
- alu_result  in  DataSize  ALU result
- alu_overflow  in  1  ALU overflow
- alu_zero  in  1  ALU zero
- pc  out  PCsize  instruction address to InstructionMemory
- ir  out  DataSize  latched instruction; feeds Control opcode/func and RegisterFile R1/R2/WR fields
- reg_write  out  1  gated write enable to RegisterFile
- wd  out  DataSize  registered write data to RegisterFile
- zero_q  out  1  alu_zero captured in EXECUTE
- state  out  3  current FSM state encoding
- busy  out  1  high in FETCH, DECODE, EXECUTE, WRITEBACK
- halted  out  1  high in HALT
- trap  out  1  high in TRAP; constant 0 when trap is compiled out
- epc  out  PCsize  pc of the trapping instruction; constant 0 when trap is compiled out
- instr_count  out  16  retired-instruction counter

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, TRAP=6. Encoding 7 is illegal and goes to IDLE.
- Reset values: state IDLE, pc 0, ir 0, wd 0, zero_q 0, instr_count 0, epc 0. All status outputs 0. reg_write 0.
- IDLE: when start=1, go to FETCH. Otherwise hold.
- FETCH: ir <= instr_in. Go to DECODE.
- DECODE: Control settles on ir.
  - If ir[31:26]==6'h3F (HALT opcode), go to HALT. pc and instr_count are not updated.
  - Otherwise go to EXECUTE.
- EXECUTE: wd <= alu_result and zero_q <= alu_zero. Go to WRITEBACK (see Configuration for overflow handling).
- WRITEBACK:
  - reg_write = ctl_regwrite & ~rst, combinational on state.
  - instr_count increments and saturates at 16'hFFFF.
  - If pc == 2^PCsize-1, go to HALT with pc unchanged; the PC does not wrap.
  - Otherwise pc <= pc+1 and go to FETCH.
- HALT / TRAP: hold all registers. On start=1, set pc <= 0 and instr_count <= 0, clear epc, and go to FETCH.
- start is ignored while busy.
- reg_write is 0 in every state except WRITEBACK.
- Arithmetic: pc is an unsigned PCsize-bit value. instr_count is unsigned, 16 bits, saturating.

## Timing
- Every non-halting instruction takes 4 cycles: FETCH→DECODE→EXECUTE→WRITEBACK. Throughput is 1 instruction per 4 clocks.
- The first FETCH is the cycle after start is sampled.
- The RegisterFile write occurs on the rising edge that ends WRITEBACK. The new pc is visible in the following FETCH cycle.
- instr_in is sampled at the end of FETCH, so InstructionMemory must be combinational on pc.
- rst mid-operation: reg_write is forced low in the same cycle rst is high, and the state is IDLE on the next edge. A reset during WRITEBACK therefore never writes.
- start and rst asserted in the same cycle: rst wins.

## Configuration
- Macro: MIPS_SEQ_OVERFLOW_TRAP_EN.
- Defined:
  - alu_overflow=1 in EXECUTE sends the FSM to TRAP instead of WRITEBACK, with epc <= pc.
  - No register write occurs, and pc and instr_count are unchanged.
  - trap=1 while in TRAP.
- Undefined:
  - Overflow is ignored and the write proceeds normally.
  - TRAP is unreachable.
  - trap and epc are tied to 0.

## Structure
- Shared package mips_pkg holds:
  - the state enum/localparams (IDLE…TRAP, 3 bits)
  - OP_HALT = 6'h3F
  - the instr_count width (16)
- One sub-module, mips_pc_reg, holds the PC register with load-zero, increment and end-of-memory detect (last_addr output).
- The FSM, ir, wd and counters stay in mips_sequencer.
- The top level instantiates mips_sequencer and wires ir fields to Control/RegisterFile, and reg_write/wd to RegisterFile.

## Test plan
- Reset then start=1 for 1 cycle, with memory holding 3 R-type adds then 0xFC000000 → states cycle 1,2,3,4 ×3, then HALT. reg_write pulses exactly 3 times, one cycle each. instr_count=3, pc=3, halted=1.
- ALU result 32'h0000_0005 during EXECUTE → wd=5 in WRITEBACK, with reg_write=ctl_regwrite. With ctl_regwrite=0, no write occurs.
- rst=1 asserted during WRITEBACK → reg_write=0 that cycle. Next cycle state=0, pc=0, instr_count=0, busy=0.
- Memory filled with non-halt instructions → pc reaches 63, WRITEBACK retires the instruction and the FSM enters HALT with pc=63 (no wrap). instr_count=64.
- With MIPS_SEQ_OVERFLOW_TRAP_EN, alu_overflow=1 at pc=2 → TRAP with epc=2, no reg_write, instr_count=2. Then start=1 → FETCH at pc=0 with trap=0. Without the macro, the same stimulus writes and continues to pc=3.
- start pulsed while busy → no effect on sequence or pc. start held high through HALT → immediate restart from pc=0.
